// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad number-entry block:
// key codes, debounce states, scan-result encoding and the key map.
package keypad_pkg;

  localparam logic [3:0]  KEY_BKSP  = 4'hB;
  localparam logic [3:0]  KEY_CLEAR = 4'hC;
  localparam logic [3:0]  KEY_ENTER = 4'hF;
  localparam logic [15:0] ENTRY_MAX = 16'd9999;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAND,
    ST_HELD
  } deb_state_e;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_KEY,
    SCAN_MULTI
  } scan_kind_e;

  typedef struct packed {
    scan_kind_e kind;
    logic [3:0] code;
  } scan_result_t;

  // Row r / column c of the physical keypad to the key code it reports.
  function automatic logic [3:0] key_at(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner: free-running dwell divider, active-low column drive,
// row synchronizer, and one classified result per full four-column scan.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_BITS = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   rows_n,
  output logic [3:0]   cols_n,
  output logic         scan_valid,
  output scan_result_t scan_result
);

  logic [SCAN_DIV_BITS-1:0] div_q, div_d;
  logic [3:0]   cols_q, cols_d;
  logic [3:0]   sync1_q, sync2_q;
  logic [1:0]   hits_q, hits_d;   // keys seen so far this scan, saturating at 2
  logic [3:0]   code_q, code_d;
  logic         valid_q, valid_d;
  scan_result_t result_q, result_d;

  logic       dwell_end;
  logic [2:0] col_hits;
  logic [2:0] hit_sum;
  logic [1:0] row_idx;
  logic [1:0] col_idx;
  logic [3:0] col_code;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    div_d     = div_q + 1'b1;
    dwell_end = &div_q;
    cols_d    = cols_q;
    hits_d    = hits_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    result_d  = result_q;
    col_hits  = 3'd0;
    row_idx   = 2'd0;

    case (cols_q)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase

    for (int r = 3; r >= 0; r--) begin
      if (!sync2_q[r]) begin
        col_hits = col_hits + 3'd1;
        row_idx  = 2'(r);
      end
    end
    hit_sum  = {1'b0, hits_q} + col_hits;
    col_code = (col_hits == 3'd1) ? key_at(row_idx, col_idx) : code_q;

    if (dwell_end) begin
      cols_d = {cols_q[2:0], cols_q[3]};
      if (col_idx == 2'd3) begin
        valid_d       = 1'b1;
        result_d.code = col_code;
        if (hit_sum == 3'd0)      result_d.kind = SCAN_NONE;
        else if (hit_sum == 3'd1) result_d.kind = SCAN_KEY;
        else                      result_d.kind = SCAN_MULTI;
        hits_d = 2'd0;
        code_d = 4'd0;
      end else begin
        hits_d = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        code_d = col_code;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      cols_q   <= 4'b1110;
      sync1_q  <= 4'hF;
      sync2_q  <= 4'hF;
      hits_q   <= 2'd0;
      code_q   <= 4'd0;
      valid_q  <= 1'b0;
      result_q <= '{kind: SCAN_NONE, code: 4'd0};
    end else begin
      div_q    <= div_d;
      cols_q   <= cols_d;
      sync1_q  <= rows_n;
      sync2_q  <= sync1_q;
      hits_q   <= hits_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign cols_n      = cols_q;
  assign scan_valid  = valid_q;
  assign scan_result = result_q;

endmodule

// File: rtl/keypad_number_entry.sv
// Keypad number entry: debounces scan results and accumulates decimal digits
// into Entry, committing to Number on '#'. KEYPAD_BACKSPACE_EN enables B = backspace.
module keypad_number_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_BITS  = 17,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [3:0]  Rows_n,
  output logic [3:0]  Cols_n,
  output logic [15:0] Entry,
  output logic [15:0] Number,
  output logic        Valid,
  output logic [3:0]  KeyCode,
  output logic        KeyStrobe
);

  localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SCANS);

  logic         scan_valid;
  scan_result_t scan_result;

  keypad_scanner #(
    .SCAN_DIV_BITS(SCAN_DIV_BITS)
  ) u_scanner (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .rows_n     (Rows_n),
    .cols_n     (Cols_n),
    .scan_valid (scan_valid),
    .scan_result(scan_result)
  );

  deb_state_e  state_q, state_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [15:0] entry_q, entry_d;
  logic [15:0] number_q, number_d;
  logic        valid_q, valid_d;
  logic [3:0]  keycode_q, keycode_d;
  logic        strobe_q, strobe_d;

  logic        accept;
  logic [3:0]  acc_code;
  logic [16:0] appended;

  // Debounce: one step per completed scan.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    rcnt_d   = rcnt_q;
    accept   = 1'b0;
    acc_code = cand_q;

    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_result.kind == SCAN_KEY) begin
            cand_d = scan_result.code;
            if (DEB_TARGET == 4'd1) begin
              accept   = 1'b1;
              acc_code = scan_result.code;
              state_d  = ST_HELD;
              cnt_d    = 4'd0;
              rcnt_d   = 4'd0;
            end else begin
              cnt_d   = 4'd1;
              state_d = ST_CAND;
            end
          end
        end
        ST_CAND: begin
          if (scan_result.kind != SCAN_KEY) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end else if (scan_result.code != cand_q) begin
            cand_d = scan_result.code;
            cnt_d  = 4'd1;
          end else if (cnt_q + 4'd1 == DEB_TARGET) begin
            accept  = 1'b1;
            state_d = ST_HELD;
            cnt_d   = 4'd0;
            rcnt_d  = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_HELD: begin
          if (scan_result.kind == SCAN_NONE) begin
            if (rcnt_q + 4'd1 == DEB_TARGET) begin
              state_d = ST_IDLE;
              rcnt_d  = 4'd0;
            end else begin
              rcnt_d = rcnt_q + 4'd1;
            end
          end else begin
            rcnt_d = 4'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Key actions, applied on the same edge as the strobe.
  always_comb begin
    entry_d   = entry_q;
    number_d  = number_q;
    valid_d   = 1'b0;
    keycode_d = keycode_q;
    strobe_d  = 1'b0;
    appended  = 17'(entry_q) * 17'd10 + 17'(acc_code);

    if (accept) begin
      strobe_d  = 1'b1;
      keycode_d = acc_code;
      if (acc_code <= 4'd9) begin
        if (appended <= 17'(ENTRY_MAX)) entry_d = appended[15:0];
      end else if (acc_code == KEY_CLEAR) begin
        entry_d = 16'd0;
      end else if (acc_code == KEY_ENTER) begin
        number_d = entry_q;
        entry_d  = 16'd0;
        valid_d  = 1'b1;
`ifdef KEYPAD_BACKSPACE_EN
      end else if (acc_code == KEY_BKSP) begin
        entry_d = entry_q / 16'd10;
`endif
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      cand_q    <= 4'd0;
      cnt_q     <= 4'd0;
      rcnt_q    <= 4'd0;
      entry_q   <= 16'd0;
      number_q  <= 16'd0;
      valid_q   <= 1'b0;
      keycode_q <= 4'd0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      entry_q   <= entry_d;
      number_q  <= number_d;
      valid_q   <= valid_d;
      keycode_q <= keycode_d;
      strobe_q  <= strobe_d;
    end
  end

  assign Entry     = entry_q;
  assign Number    = number_q;
  assign Valid     = valid_q;
  assign KeyCode   = keycode_q;
  assign KeyStrobe = strobe_q;

endmodule

// File: tb/tb_keypad_number_entry.sv
// Directed bench for keypad_number_entry with a behavioural keypad matrix
// driven from the column outputs (SCAN_DIV_BITS=2, DEBOUNCE_SCANS=2).
module tb_keypad_number_entry;

  localparam int SCAN = 16;  // clocks per full scan: 4 columns x 2^2

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [3:0]  Rows_n;
  logic [3:0]  Cols_n;
  logic [15:0] Entry;
  logic [15:0] Number;
  logic        Valid;
  logic [3:0]  KeyCode;
  logic        KeyStrobe;

  logic [15:0] pressed = 16'd0;  // bit r*4+c = key at row r, column c held
  int          errors = 0;
  int          checks = 0;
  int          strobes = 0;
  int          valids = 0;
  logic [3:0]  last_code = 4'd0;
  int          exp_strobes = 0;
  int          exp_bksp = 0;

  keypad_number_entry #(
    .SCAN_DIV_BITS (2),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Rows_n   (Rows_n),
    .Cols_n   (Cols_n),
    .Entry    (Entry),
    .Number   (Number),
    .Valid    (Valid),
    .KeyCode  (KeyCode),
    .KeyStrobe(KeyStrobe)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    Rows_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !Cols_n[c]) Rows_n[r] = 1'b0;
  end

  always @(negedge Clk) begin
    if (Rst_n) begin
      if (KeyStrobe) begin
        strobes   <= strobes + 1;
        last_code <= KeyCode;
      end
      if (Valid) valids <= valids + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int key_idx(input logic [3:0] code);
    case (code)
      4'h1: return 0;   4'h2: return 1;   4'h3: return 2;   4'hA: return 3;
      4'h4: return 4;   4'h5: return 5;   4'h6: return 6;   4'hB: return 7;
      4'h7: return 8;   4'h8: return 9;   4'h9: return 10;  4'hC: return 11;
      4'hE: return 12;  4'h0: return 13;  4'hF: return 14;  default: return 15;
    endcase
  endfunction

  function automatic logic [15:0] key_mask(input logic [3:0] code);
    return 16'd1 << key_idx(code);
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  // Align to just after the edge that starts column 0 of a new scan.
  task automatic sync_scan();
    logic [3:0] prev;
    bit         found;
    prev  = Cols_n;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge Clk);
      if (prev == 4'b0111 && Cols_n == 4'b1110) found = 1'b1;
      prev = Cols_n;
    end
    #1;
    check("scan_sync", 32'(found), 32'd1);
  endtask

  // Steady press for 3 scans then steady release for 3 scans.
  task automatic type_key(input logic [3:0] code);
    sync_scan();
    pressed = key_mask(code);
    wait_cycles(3 * SCAN);
    pressed = 16'd0;
    wait_cycles(3 * SCAN);
    exp_strobes++;
  endtask

  initial begin
`ifdef KEYPAD_BACKSPACE_EN
    exp_bksp = 1;
`endif
    // Reset state
    wait_cycles(3);
    check("rst_cols", 32'(Cols_n), 32'b1110);
    check("rst_entry", 32'(Entry), 0);
    check("rst_number", 32'(Number), 0);
    check("rst_keycode", 32'(KeyCode), 0);
    check("rst_valid", 32'(Valid), 0);
    check("rst_strobe", 32'(KeyStrobe), 0);
    Rst_n = 1'b1;

    // Hold '5' for 3 scans: strobe at the end of scan 2, then release
    sync_scan();
    pressed = key_mask(4'h5);
    wait_cycles(28);
    check("k5_no_early_strobe", 32'(strobes), 0);
    wait_cycles(8);
    check("k5_strobe", 32'(strobes), 1);
    check("k5_code", 32'(last_code), 5);
    check("k5_entry", 32'(Entry), 5);
    wait_cycles(12);
    pressed = 16'd0;
    wait_cycles(3 * SCAN);
    check("k5_single_strobe", 32'(strobes), 1);
    exp_strobes = 1;

    // Clear, then 1 2 3 4 5: the fifth digit would exceed 9999
    type_key(4'hC);
    check("clear_entry", 32'(Entry), 0);
    type_key(4'h1);
    type_key(4'h2);
    type_key(4'h3);
    type_key(4'h4);
    check("digits_entry", 32'(Entry), 1234);
    type_key(4'h5);
    check("overflow_entry", 32'(Entry), 1234);
    check("overflow_strobe", 32'(strobes), exp_strobes);
    check("overflow_code", 32'(last_code), 5);

    // 9 8 B #
    type_key(4'hC);
    type_key(4'h9);
    type_key(4'h8);
    check("entry_98", 32'(Entry), 98);
    type_key(4'hB);
    check("bksp_code", 32'(last_code), 11);
    check("bksp_entry", 32'(Entry), exp_bksp ? 9 : 98);
    type_key(4'hF);
    check("enter_number", 32'(Number), exp_bksp ? 9 : 98);
    check("enter_valid_cycles", 32'(valids), 1);
    check("enter_entry", 32'(Entry), 0);

    // Bouncing '7': KEY NONE KEY NONE never accepted
    sync_scan();
    for (int i = 0; i < 2; i++) begin
      pressed = key_mask(4'h7);
      wait_cycles(SCAN);
      pressed = 16'd0;
      wait_cycles(SCAN);
    end
    wait_cycles(SCAN);
    check("bounce_no_strobe", 32'(strobes), exp_strobes);
    type_key(4'h7);
    check("steady7_strobe", 32'(strobes), exp_strobes);
    check("steady7_code", 32'(last_code), 7);
    check("steady7_entry", 32'(Entry), 7);

    // 1 and 2 together, then 2 released
    sync_scan();
    pressed = key_mask(4'h1) | key_mask(4'h2);
    wait_cycles(2 * SCAN);
    check("multi_no_strobe", 32'(strobes), exp_strobes);
    pressed = key_mask(4'h1);
    wait_cycles(3 * SCAN);
    exp_strobes++;
    check("after_multi_strobe", 32'(strobes), exp_strobes);
    check("after_multi_code", 32'(last_code), 1);
    pressed = 16'd0;
    wait_cycles(3 * SCAN);
    check("after_multi_entry", 32'(Entry), 71);

    // Reset while '3' is a candidate
    sync_scan();
    pressed = key_mask(4'h3);
    wait_cycles(SCAN + 4);
    Rst_n = 1'b0;
    #1;
    check("midrst_cols", 32'(Cols_n), 32'b1110);
    check("midrst_entry", 32'(Entry), 0);
    check("midrst_number", 32'(Number), 0);
    check("midrst_keycode", 32'(KeyCode), 0);
    check("midrst_valid", 32'(Valid), 0);
    check("midrst_strobe", 32'(KeyStrobe), 0);
    pressed = 16'd0;
    wait_cycles(3);
    Rst_n = 1'b1;
    wait_cycles(1);
    check("postrst_cols", 32'(Cols_n), 32'b1110);
    wait_cycles(4 * SCAN);
    check("postrst_no_strobe", 32'(strobes), exp_strobes);

    // Enter with Entry=0, then 4 2 B 0
    type_key(4'hF);
    check("enter0_number", 32'(Number), 0);
    check("enter0_valid_cycles", 32'(valids), 2);
    type_key(4'h4);
    type_key(4'h2);
    check("entry_42", 32'(Entry), 42);
    type_key(4'hB);
    check("b42_code", 32'(last_code), 11);
    check("b42_entry", 32'(Entry), exp_bksp ? 4 : 42);
    type_key(4'h0);
    check("zero_digit_entry", 32'(Entry), exp_bksp ? 40 : 420);
    check("final_strobe_count", 32'(strobes), exp_strobes);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
